// File: rtl/sap_fetch_sequencer.sv
// SAP fetch sequencer: PC, MAR, IR, MDR and one-hot T1..T6 ring counter driving the program ROM.
// Optional feature: define SAP_JMP_EN to make opcode 4'h3 a JMP (pc <= operand in T4).
//
// state | meaning
// T1    | MAR <= pc
// T2    | pc <= pc + 1
// T3    | ROM read, IR <= rom_data at end of cycle
// T4    | mem-ref: MAR <= operand; HLT: freeze here; JMP (optional): pc <= operand
// T5    | mem-ref: ROM read, mdr <= rom_data at end of cycle
// T6    | idle, next cycle starts the following instruction
module sap_fetch_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     low_rst,
   input  logic                     run,
   input  logic [DATA_W-1:0]        rom_data,
   output logic [ADDR_W-1:0]        rom_addr,
   output logic                     low_rom_o_en,
   output logic [ADDR_W-1:0]        pc,
   output logic [DATA_W-ADDR_W-1:0] opcode,
   output logic [ADDR_W-1:0]        operand,
   output logic [DATA_W-1:0]        mdr,
   output logic [5:0]               tstate,
   output logic                     halted
);

   localparam int OP_W = DATA_W - ADDR_W;

   localparam logic [OP_W-1:0] OP_LDA   = OP_W'(4'h0);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h1);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h2);
   localparam logic [OP_W-1:0] OP_OUT_M = OP_W'(4'hE);
   localparam logic [OP_W-1:0] OP_HLT   = OP_W'(4'hF);
`ifdef SAP_JMP_EN
   localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h3);
`endif

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_t;

   tstate_t             state;
   logic [ADDR_W-1:0]   mar;
   logic [DATA_W-1:0]   ir;
   logic                mem_ref;

   assign opcode   = ir[DATA_W-1:ADDR_W];
   assign operand  = ir[ADDR_W-1:0];
   assign rom_addr = mar;
   assign tstate   = state;

   assign mem_ref = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                    (opcode == OP_SUB) || (opcode == OP_OUT_M);

   // ROM is enabled only in the two read slots; opcode is already the new IR by T5.
   assign low_rom_o_en = ~((state == T3) || ((state == T5) && mem_ref));

   always_ff @(posedge clk) begin
      if (!low_rst) begin
         state  <= T1;
         pc     <= '0;
         mar    <= '0;
         ir     <= '0;
         mdr    <= '0;
         halted <= 1'b0;
      end else if (run && !halted) begin
         unique case (state)
            T1: begin
               mar   <= pc;
               state <= T2;
            end
            T2: begin
               pc    <= pc + ADDR_W'(1);
               state <= T3;
            end
            T3: begin
               ir    <= rom_data;
               state <= T4;
            end
            T4: begin
               if (mem_ref) begin
                  mar <= operand;
               end
`ifdef SAP_JMP_EN
               if (opcode == OP_JMP) begin
                  pc <= operand;
               end
`endif
               if (opcode == OP_HLT) begin
                  halted <= 1'b1;
               end else begin
                  state <= T5;
               end
            end
            T5: begin
               if (mem_ref) begin
                  mdr <= rom_data;
               end
               state <= T6;
            end
            T6: begin
               state <= T1;
            end
            default: begin
               state <= T1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sap_fetch_sequencer.sv
// Self-checking bench for sap_fetch_sequencer: directed scenarios plus randomized run/reset
// against an instruction-level reference model; emulates the 16x8 ROM.
module tb_sap_fetch_sequencer;

   logic       clk = 1'b0;
   logic       low_rst;
   logic       run;
   logic [7:0] rom_data;
   logic [3:0] rom_addr;
   logic       low_rom_o_en;
   logic [3:0] pc;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [7:0] mdr;
   logic [5:0] tstate;
   logic       halted;

   logic [7:0] rom [16];

   int checks = 0;
   int errors = 0;

   // reference model state: step index 0..5 stands for T1..T6
   int       m_pc, m_mar, m_ir, m_mdr, m_t;
   bit       m_halt;

   sap_fetch_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk          (clk),
      .low_rst      (low_rst),
      .run          (run),
      .rom_data     (rom_data),
      .rom_addr     (rom_addr),
      .low_rom_o_en (low_rom_o_en),
      .pc           (pc),
      .opcode       (opcode),
      .operand      (operand),
      .mdr          (mdr),
      .tstate       (tstate),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   assign rom_data = (!low_rom_o_en) ? rom[rom_addr] : 8'h00;

   function automatic bit is_mem_ref(input int op);
      return (op == 0) || (op == 1) || (op == 2) || (op == 14);
   endfunction

   function automatic bit is_jmp(input int op);
`ifdef SAP_JMP_EN
      return op == 3;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge(input bit r, input bit rn);
      int op;
      if (!r) begin
         m_pc = 0; m_mar = 0; m_ir = 0; m_mdr = 0; m_t = 0; m_halt = 0;
      end else if (rn && !m_halt) begin
         op = m_ir / 16;
         if (m_t == 0) m_mar = m_pc;
         if (m_t == 1) m_pc = (m_pc + 1) % 16;
         if (m_t == 2) m_ir = int'(rom[m_mar]);
         if (m_t == 3) begin
            if (is_mem_ref(op)) m_mar = m_ir % 16;
            if (is_jmp(op)) m_pc = m_ir % 16;
            if (op == 15) m_halt = 1;
         end
         if (m_t == 4 && is_mem_ref(op)) m_mdr = int'(rom[m_mar]);
         if (!m_halt) m_t = (m_t + 1) % 6;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int  op;
      bit  exp_oe;
      op = m_ir / 16;
      exp_oe = !((m_t == 2) || (m_t == 4 && is_mem_ref(op)));
      check("tstate",   32'(tstate),       32'(1 << m_t));
      check("pc",       32'(pc),           32'(m_pc));
      check("rom_addr", 32'(rom_addr),     32'(m_mar));
      check("oe",       32'(low_rom_o_en), 32'(exp_oe));
      check("opcode",   32'(opcode),       32'(op));
      check("operand",  32'(operand),      32'(m_ir % 16));
      check("mdr",      32'(mdr),          32'(m_mdr));
      check("halted",   32'(halted),       32'(m_halt));
   endtask

   task automatic tick(input bit r, input bit rn);
      low_rst = r;
      run     = rn;
      @(posedge clk);
      model_edge(r, rn);
      #1;
      check_all();
   endtask

   initial begin
      int n;
      logic [3:0] exp_mar;
      low_rst = 1'b0;
      run     = 1'b1;
      for (int i = 0; i < 16; i++) rom[i] = 8'h50;
      m_pc = 0; m_mar = 0; m_ir = 0; m_mdr = 0; m_t = 0; m_halt = 0;

      // 1: reset with run held high
      tick(0, 1);
      tick(0, 1);
      check("rst_tstate", 32'(tstate), 32'h01);
      check("rst_oe",     32'(low_rom_o_en), 32'h1);

      // 2: fetch of a mem-ref instruction
      rom[0]  = 8'h1A;
      rom[10] = 8'hC3;
      for (int i = 0; i < 6; i++) tick(1, 1);
      check("fetch_mdr", 32'(mdr), 32'hC3);

      // 3: pc wrap over 16 non-mem-ref instructions
      for (int i = 0; i < 16; i++) rom[i] = 8'h50 | 8'(i);
      tick(0, 1);
      for (int i = 0; i < 96; i++) tick(1, 1);
      check("wrap_pc", 32'(pc), 32'h0);
      for (int i = 0; i < 3; i++) tick(1, 1);
      check("wrap_ir", 32'(operand), 32'h0);

      // 4: pause during T3
      rom[0] = 8'h2B;
      rom[1] = 8'h50;
      tick(0, 1);
      tick(1, 1);
      tick(1, 1);
      for (int i = 0; i < 3; i++) tick(1, 0);
      check("pause_oe", 32'(low_rom_o_en), 32'h0);
      tick(1, 1);
      check("pause_ir", 32'(opcode), 32'h2);

      // 5: halt at address 2
      rom[0] = 8'h50; rom[1] = 8'h61; rom[2] = 8'hF0;
      tick(0, 1);
      n = 0;
      while (!m_halt && n < 40) begin
         tick(1, 1);
         n++;
      end
      check("halt_reached", 32'(m_halt), 32'h1);
      for (int i = 0; i < 20; i++) tick(1, (i % 2) == 0);
      check("halt_tstate", 32'(tstate), 32'h08);
      tick(0, 1);
      check("halt_rst_pc", 32'(pc), 32'h0);

      // 6: opcode 3 at address 0
      rom[0] = 8'h37;
      tick(0, 1);
      for (int i = 0; i < 7; i++) tick(1, 1);
`ifdef SAP_JMP_EN
      exp_mar = 4'h7;
`else
      exp_mar = 4'h1;
`endif
      check("jmp_mar", 32'(rom_addr), 32'(exp_mar));

      // random program, random pauses and occasional resets
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      rom[15] = 8'h3F;
      tick(0, 1);
      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = ($urandom_range(0, 299) != 0);
         if (m_halt && $urandom_range(0, 9) == 0) r = 1'b0;
         if (i % 500 == 499) rom[$urandom_range(0, 15)] = 8'($urandom);
         tick(r, $urandom_range(0, 9) < 8);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
